// File: rtl/slow_pulse_collector.sv
// slow_pulse_collector
//   Slow-domain consumer of a fast-to-slow pulse synchronizer. The first pulse
//   seen while idle opens a window of WIN_LEN clk_s edges. Every pulse inside
//   the window is counted, saturating at 2^CNT_W-1. When the window closes, the
//   count is presented as a valid/ready report. Pulses that arrive while a
//   report is pending are discarded and recorded in a sticky drop flag.
//
// Ports
//   clk_s      in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   pulse_in   in   event pulse, synchronous to clk_s (one event per high cycle)
//   rpt_ready  in   downstream accepts the report (ignored outside REPORT)
//   rpt_valid  out  window report presented
//   rpt_count  out  number of events in the window (saturating)
//   rpt_sat    out  count saturated during the window
//   drop       out  sticky: an event was discarded (cleared by reset only)
//   busy       out  FSM not idle
module slow_pulse_collector #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk_s,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             drop,
    output logic             busy
);

    // Timer only needs to reach WIN_LEN-1
    localparam int TW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] count_q;
    logic             sat_q;
    logic             drop_q;

    always_ff @(posedge clk_s) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Opening pulse is window edge 0 and counts as the first event
                    if (pulse_in) begin
                        state_q <= COLLECT;
                        count_q <= CNT_W'(1);
                        sat_q   <= 1'b0;
                        timer_q <= TW'(1);
                    end
                end
                COLLECT: begin
                    if (pulse_in) begin
                        if (count_q == '1) begin
                            sat_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    // timer_q holds the index of the current window edge
                    if (timer_q == TIMER_LAST) begin
                        state_q <= REPORT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                REPORT: begin
                    if (pulse_in) begin
                        drop_q <= 1'b1;
                    end
                    // count/sat are kept so the report values persist after acceptance
                    if (rpt_ready) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rpt_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign rpt_count = count_q;
    assign rpt_sat   = sat_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_slow_pulse_collector.sv
module tb_slow_pulse_collector;

    localparam int WIN_LEN = 16;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk_s = 1'b0;
    logic             rst;
    logic             pulse_in;
    logic             rpt_ready;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             drop;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: absolute edge numbers and an unbounded event tally
    int cyc      = 0;
    bit m_win    = 1'b0;
    bit m_pend   = 1'b0;
    bit m_drop   = 1'b0;
    int m_end    = 0;
    int m_events = 0;

    slow_pulse_collector #(
        .WIN_LEN(WIN_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_s    (clk_s),
        .rst      (rst),
        .pulse_in (pulse_in),
        .rpt_ready(rpt_ready),
        .rpt_valid(rpt_valid),
        .rpt_count(rpt_count),
        .rpt_sat  (rpt_sat),
        .drop     (drop),
        .busy     (busy)
    );

    always #5 clk_s = ~clk_s;

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit p, input bit r, input bit rs);
        if (rs) begin
            m_win    = 1'b0;
            m_pend   = 1'b0;
            m_drop   = 1'b0;
            m_events = 0;
        end else if (m_pend) begin
            if (p) m_drop = 1'b1;
            if (r) m_pend = 1'b0;
        end else if (m_win) begin
            m_events += int'(p);
            if (cyc == m_end) begin
                m_pend = 1'b1;
                m_win  = 1'b0;
            end
        end else if (p) begin
            m_win    = 1'b1;
            m_end    = cyc + WIN_LEN - 1;
            m_events = 1;
        end
    endtask

    task automatic compare_all();
        check("valid", int'(rpt_valid), int'(m_pend));
        check("busy",  int'(busy),      int'(m_win || m_pend));
        check("count", int'(rpt_count), (m_events > MAXC) ? MAXC : m_events);
        check("sat",   int'(rpt_sat),   int'(m_events > MAXC));
        check("drop",  int'(drop),      int'(m_drop));
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next falling edge
    task automatic step(input bit p, input bit r, input bit rs);
        pulse_in  = p;
        rpt_ready = r;
        rst       = rs;
        @(posedge clk_s);
        model_edge(p, r, rs);
        cyc++;
        @(negedge clk_s);
        compare_all();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rpt_valid && n < 40) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check(tag, int'(rpt_valid), 1);
    endtask

    initial begin
        pulse_in  = 1'b0;
        rpt_ready = 1'b0;
        rst       = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst_valid", int'(rpt_valid), 0);
        check("rst_count", int'(rpt_count), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_drop",  int'(drop), 0);

        // Single pulse, ready held high
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check("single_busy",  int'(busy), 1);
            check("single_valid", int'(rpt_valid), int'(k == 15));
        end
        check("single_count", int'(rpt_count), 1);
        check("single_sat",   int'(rpt_sat), 0);
        step(1'b0, 1'b1, 1'b0);
        check("single_valid_fall", int'(rpt_valid), 0);
        check("single_idle",       int'(busy), 0);

        // Pulses at window edges 0, 5, 15 plus one on the accepting edge
        for (int k = 0; k <= 16; k++) begin
            step((k == 0) || (k == 5) || (k == 15) || (k == 16), 1'b1, 1'b0);
            if (k == 15) check("win3_count", int'(rpt_count), 3);
        end
        check("win3_drop", int'(drop), 1);
        step(1'b0, 1'b0, 1'b1);

        // Saturation: 16 consecutive pulses
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0);
        check("sat_count", int'(rpt_count), MAXC);
        check("sat_flag",  int'(rpt_sat), 1);
        check("sat_valid", int'(rpt_valid), 1);
        step(1'b0, 1'b1, 1'b0);

        // Back-pressure: ready low for 10 cycles after valid rises
        step(1'b1, 1'b0, 1'b0);
        wait_valid("bp_valid_rise");
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("bp_valid_hold", int'(rpt_valid), 1);
            check("bp_count_hold", int'(rpt_count), 1);
        end
        step(1'b0, 1'b1, 1'b0);
        check("bp_valid_fall", int'(rpt_valid), 0);

        // Reset at window edge 8 with pulses present
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("mid_rst_valid", int'(rpt_valid), 0);
        check("mid_rst_count", int'(rpt_count), 0);
        check("mid_rst_sat",   int'(rpt_sat), 0);
        check("mid_rst_drop",  int'(drop), 0);
        check("mid_rst_busy",  int'(busy), 0);
        step(1'b1, 1'b0, 1'b0);
        check("fresh_count", int'(rpt_count), 1);
        check("fresh_busy",  int'(busy), 1);

        // Pulse on the accepting edge, then a pulse in the following idle cycle
        wait_valid("acc_valid_rise");
        step(1'b1, 1'b1, 1'b0);
        check("acc_drop",  int'(drop), 1);
        check("acc_valid", int'(rpt_valid), 0);
        check("acc_idle",  int'(busy), 0);
        step(1'b1, 1'b1, 1'b0);
        check("reopen_busy",  int'(busy), 1);
        check("reopen_count", int'(rpt_count), 1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 150) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/slow_pulse_collector.md
SLOW_PULSE_COLLECTOR -- requirements
Module: slow_pulse_collector

Interface
REQ-001 The block SHALL be the slow-domain consumer of the 1-bit fast-to-slow handshake synchronizer output, taking its single-cycle clk_s pulses as pulse_in.
REQ-002 Parameter WIN_LEN, default 16, SHALL set the collection window length in clk_s cycles; legal range 2..1024.
REQ-003 Parameter CNT_W, default 4, SHALL set the pulse-count width; legal range 2..16.
REQ-004 Port clk_s  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port pulse_in  input  1  SHALL be the event pulse, already synchronous to clk_s; each high cycle counts as one event.
REQ-007 Port rpt_ready  input  1  SHALL be the downstream acceptance of a report.
REQ-008 Port rpt_valid  output  1  SHALL flag that a window report is presented.
REQ-009 Port rpt_count  output  CNT_W  SHALL carry the number of events in the reported window.
REQ-010 Port rpt_sat  output  1  SHALL flag that rpt_count saturated in the reported window.
REQ-011 Port drop  output  1  SHALL be a sticky flag set when an event is discarded.
REQ-012 Port busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, COLLECT and REPORT; all outputs SHALL be registered or decoded from registered state only.
REQ-014 In IDLE, a sampled pulse_in=1 SHALL move the FSM to COLLECT, load the count with 1, clear sat, and load the window timer with 1.
REQ-015 In COLLECT, the window timer SHALL increment every cycle, and each sampled pulse_in=1 SHALL increment the count.
REQ-016 The window SHALL span exactly WIN_LEN consecutive edges, starting at the edge that sampled the first pulse, at t..t+WIN_LEN-1.
REQ-017 At edge t+WIN_LEN-1, the block SHALL count any pulse on that edge, then enter REPORT with rpt_valid=1, visible from the following cycle.
REQ-018 The count SHALL saturate at 2^CNT_W-1; an event arriving at saturation SHALL leave the count unchanged and set sat.
REQ-019 In REPORT, rpt_valid, rpt_count and rpt_sat SHALL hold stable until an edge with rpt_valid=1 and rpt_ready=1.
REQ-020 On the accepting edge, the FSM SHALL return to IDLE and rpt_valid SHALL fall; rpt_count and rpt_sat SHALL retain their last values.
REQ-021 With rpt_ready held at 1, rpt_valid SHALL be high for exactly one cycle.
REQ-022 A pulse sampled in REPORT, including on the accepting edge, SHALL be discarded and SHALL set drop.
REQ-023 drop SHALL clear only on reset.
REQ-024 A pulse in the first IDLE cycle after acceptance SHALL start a new window, per REQ-014.
REQ-025 rpt_ready SHALL be ignored outside REPORT.

Reset
REQ-026 When rst=1 on an edge, the block SHALL enter IDLE and clear the timer and count, regardless of the current state.
REQ-027 On that edge, the outputs SHALL reset to rpt_valid=0, rpt_count=0, rpt_sat=0, drop=0 and busy=0.
REQ-028 rst SHALL take priority over pulse_in and rpt_ready on the same edge; a report that is pending when reset is asserted SHALL be lost.

Verification (WIN_LEN=16, CNT_W=4)
REQ-029 The bench SHALL apply a single pulse at edge t with rpt_ready=1, and SHALL check busy=1 from t+1, rpt_valid=1 only in the cycle after t+15, rpt_count=1, rpt_sat=0, and busy=0 after t+16.
REQ-030 The bench SHALL apply pulses at window edges 0, 5 and 15, then a pulse at edge 16, and SHALL check rpt_count=3 and drop=1.
REQ-031 The bench SHALL hold pulse_in=1 for 16 consecutive edges and SHALL check rpt_count=15 and rpt_sat=1.
REQ-032 The bench SHALL hold rpt_ready=0 for 10 cycles after rpt_valid rises, then set it to 1, and SHALL check that rpt_valid and rpt_count stay stable and that rpt_valid falls on the next edge.
REQ-033 The bench SHALL assert rst for one edge at window edge 8 with pulses present, and SHALL check all outputs are 0, the FSM is in IDLE, and the next pulse starts a fresh window with count=1.
REQ-034 The bench SHALL apply a pulse on the accepting edge followed by a pulse in the next cycle, and SHALL check that the first pulse is dropped (drop=1) and the second opens a new window.
